// File: rtl/shift_arbiter.sv
`default_nettype none
// shift_arbiter: two valid/ready requesters share one 16-bit barrel shifter
// through a round-robin grant; the result is returned on a registered channel. Rev 1.0

module shifter (
  input  logic [15:0] data,
  input  logic [3:0]  shamt,
  input  logic [1:0]  mode,
  output logic [15:0] result
);
  always_comb begin
    case (mode)
      2'b00:   result = data << shamt;
      2'b01:   result = $signed(data) >>> shamt;
      // The left-shift term is 16 bits wide, so shamt=0 shifts it fully out.
      2'b10:   result = (data >> shamt) | (data << (5'd16 - {1'b0, shamt}));
      default: result = 16'h0000;
    endcase
  end
endmodule

module shift_arbiter #(
  parameter bit PRIO_INIT = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [15:0] req0_data,
  input  logic [3:0]  req0_shamt,
  input  logic [1:0]  req0_mode,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [15:0] req1_data,
  input  logic [3:0]  req1_shamt,
  input  logic [1:0]  req1_mode,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic        resp_id,
  output logic [15:0] resp_data,
  output logic        resp_zero,
  output logic        resp_err
);
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic        prio_q, prio_d;
  logic [15:0] op_data_q, op_data_d;
  logic [3:0]  op_shamt_q, op_shamt_d;
  logic [1:0]  op_mode_q, op_mode_d;
  logic        op_id_q, op_id_d;
  logic        resp_valid_q, resp_valid_d;
  logic        resp_id_q, resp_id_d;
  logic [15:0] resp_data_q, resp_data_d;
  logic        resp_zero_q, resp_zero_d;
  logic        resp_err_q, resp_err_d;

  logic        grant;
  logic        offer;
  logic        accept;
  logic [15:0] shift_res;

  shifter u_shifter (
    .data   (op_data_q),
    .shamt  (op_shamt_q),
    .mode   (op_mode_q),
    .result (shift_res)
  );

  // With a single requester valid it wins outright; only a tie consults prio.
  always_comb begin
    grant      = (req0_valid && req1_valid) ? prio_q : req1_valid;
    offer      = !rst && (state_q == S_IDLE) && (req0_valid || req1_valid);
    req0_ready = offer && !grant;
    req1_ready = offer && grant;
    accept     = (req0_valid && req0_ready) || (req1_valid && req1_ready);
  end

  always_comb begin
    state_d      = state_q;
    prio_d       = prio_q;
    op_data_d    = op_data_q;
    op_shamt_d   = op_shamt_q;
    op_mode_d    = op_mode_q;
    op_id_d      = op_id_q;
    resp_valid_d = resp_valid_q;
    resp_id_d    = resp_id_q;
    resp_data_d  = resp_data_q;
    resp_zero_d  = resp_zero_q;
    resp_err_d   = resp_err_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          op_data_d  = grant ? req1_data  : req0_data;
          op_shamt_d = grant ? req1_shamt : req0_shamt;
          op_mode_d  = grant ? req1_mode  : req0_mode;
          op_id_d    = grant;
          prio_d     = !grant;
          state_d    = S_EXEC;
        end
      end
      S_EXEC: begin
        resp_data_d  = shift_res;
        resp_zero_d  = (shift_res == 16'h0000);
        resp_err_d   = (op_mode_q == 2'b11);
        resp_id_d    = op_id_q;
        resp_valid_d = 1'b1;
        state_d      = S_RESP;
      end
      S_RESP: begin
        if (resp_ready) begin
          resp_valid_d = 1'b0;
          state_d      = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      prio_q       <= PRIO_INIT;
      op_data_q    <= 16'h0000;
      op_shamt_q   <= 4'h0;
      op_mode_q    <= 2'b00;
      op_id_q      <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_id_q    <= 1'b0;
      resp_data_q  <= 16'h0000;
      resp_zero_q  <= 1'b0;
      resp_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      prio_q       <= prio_d;
      op_data_q    <= op_data_d;
      op_shamt_q   <= op_shamt_d;
      op_mode_q    <= op_mode_d;
      op_id_q      <= op_id_d;
      resp_valid_q <= resp_valid_d;
      resp_id_q    <= resp_id_d;
      resp_data_q  <= resp_data_d;
      resp_zero_q  <= resp_zero_d;
      resp_err_q   <= resp_err_d;
    end
  end

  assign resp_valid = resp_valid_q;
  assign resp_id    = resp_id_q;
  assign resp_data  = resp_data_q;
  assign resp_zero  = resp_zero_q;
  assign resp_err   = resp_err_q;
endmodule

`default_nettype wire

// File: tb/tb_shift_arbiter.sv
`default_nettype none
// tb_shift_arbiter: randomized and directed checks of shift_arbiter against an
// arithmetic reference model of the shift and round-robin rules. Rev 1.0
module tb_shift_arbiter;
  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req0_ready, req1_valid, req1_ready;
  logic [15:0] req0_data, req1_data;
  logic [3:0]  req0_shamt, req1_shamt;
  logic [1:0]  req0_mode, req1_mode;
  logic        resp_valid, resp_ready, resp_id, resp_zero, resp_err;
  logic [15:0] resp_data;

  int   n_checks = 0;
  int   n_pass   = 0;
  logic m_prio   = 1'b0;

  typedef struct {logic id; logic [15:0] data;} exp_t;

  shift_arbiter #(.PRIO_INIT(1'b0)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_data(req0_data),
    .req0_shamt(req0_shamt), .req0_mode(req0_mode),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_data(req1_data),
    .req1_shamt(req1_shamt), .req1_mode(req1_mode),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
    .resp_data(resp_data), .resp_zero(resp_zero), .resp_err(resp_err)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference: shifts as multiplication/floor-division by 2**shamt.
  function automatic logic [15:0] ref_shift(input logic [15:0] d, input logic [3:0] sh,
                                            input logic [1:0] m);
    int p, v, u;
    p = 2 ** int'(sh);
    u = int'(d);
    case (m)
      2'd0: return 16'((u * p) % 65536);
      2'd1: begin
        v = (u >= 32768) ? u - 65536 : u;
        v = (v >= 0) ? v / p : -((-v + p - 1) / p);
        return 16'(v);
      end
      2'd2: return 16'(u / p + (u % p) * (65536 / p));
      default: return 16'h0000;
    endcase
  endfunction

  task automatic set_req(input bit id, input bit v, input logic [15:0] d,
                         input logic [3:0] sh, input logic [1:0] m);
    if (id) begin
      req1_valid = v; req1_data = d; req1_shamt = sh; req1_mode = m;
    end else begin
      req0_valid = v; req0_data = d; req0_shamt = sh; req0_mode = m;
    end
  endtask

  task automatic pulse_reset();
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    m_prio = 1'b0;
  endtask

  // One request from a single requester with resp_ready high; lat counts
  // negedges from the accepting edge until resp_valid is seen (-1 on timeout).
  task automatic run_one(input bit id, input logic [15:0] d, input logic [3:0] sh,
                         input logic [1:0] m, output int lat, output logic [15:0] rd,
                         output logic rz, output logic re, output logic ri);
    int n;
    lat = -1; rd = 'x; rz = 'x; re = 'x; ri = 'x;
    set_req(id, 1'b1, d, sh, m);
    resp_ready = 1'b1;
    n = 0;
    @(negedge clk);
    while (!(id ? req1_ready : req0_ready) && n < 20) begin
      @(negedge clk); n++;
    end
    if (n >= 20) begin
      set_req(id, 1'b0, d, sh, m);
      return;
    end
    @(posedge clk); #1;
    set_req(id, 1'b0, 16'h0, 4'h0, 2'b00);
    m_prio = !id;
    n = 0;
    do begin @(negedge clk); n++; end while (!resp_valid && n < 20);
    if (resp_valid) lat = n;
    rd = resp_data; rz = resp_zero; re = resp_err; ri = resp_id;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; resp_ready = 1'b0;
    set_req(0, 1'b1, 16'h1111, 4'h1, 2'b00);
    set_req(1, 1'b1, 16'h2222, 4'h2, 2'b00);
    @(negedge clk);
    n_checks++; if (req0_ready !== 1'b0 || req1_ready !== 1'b0) $display("FAIL reset_ready: got %b%b want 00", req0_ready, req1_ready); else n_pass++;
    n_checks++; if ({resp_valid, resp_id, resp_zero, resp_err} !== 4'b0000) $display("FAIL reset_flags: got %b want 0000", {resp_valid, resp_id, resp_zero, resp_err}); else n_pass++;
    n_checks++; if (resp_data !== 16'h0000) $display("FAIL reset_data: got %h want 0000", resp_data); else n_pass++;
    @(posedge clk); #1 rst = 1'b0;
    m_prio = 1'b0;
    @(negedge clk);
    n_checks++; if ({req0_ready, req1_ready} !== 2'b10) $display("FAIL reset_prio_init: got %b want 10", {req0_ready, req1_ready}); else n_pass++;
    #1;
    set_req(0, 1'b0, 16'h0, 4'h0, 2'b00);
    set_req(1, 1'b0, 16'h0, 4'h0, 2'b00);
    #1;
    n_checks++; if ({req0_ready, req1_ready} !== 2'b00) $display("FAIL idle_no_valid_ready: got %b want 00", {req0_ready, req1_ready}); else n_pass++;
    @(posedge clk); #1;
  endtask

  task automatic test_single();
    int lat; logic [15:0] rd; logic rz, re, ri;
    run_one(0, 16'h0001, 4'd4, 2'b00, lat, rd, rz, re, ri);
    n_checks++; if (lat !== 2) $display("FAIL single_latency: got %0d want 2", lat); else n_pass++;
    n_checks++; if (rd !== 16'h0010) $display("FAIL single_data: got %h want 0010", rd); else n_pass++;
    n_checks++; if ({ri, rz, re} !== 3'b000) $display("FAIL single_id_zero_err: got %b want 000", {ri, rz, re}); else n_pass++;
    @(negedge clk);
    n_checks++; if (resp_valid !== 1'b0) $display("FAIL single_back_to_idle: resp_valid got %b want 0", resp_valid); else n_pass++;
  endtask

  task automatic test_modes();
    logic [15:0] td [8] = '{16'h8000, 16'h4000, 16'h0001, 16'h8000, 16'hA5A5, 16'hA5A5, 16'hA5A5, 16'hFFFF};
    logic [3:0]  ts [8] = '{4'd15, 4'd14, 4'd1, 4'd1, 4'd0, 4'd0, 4'd0, 4'd15};
    logic [1:0]  tm [8] = '{2'b01, 2'b01, 2'b10, 2'b00, 2'b00, 2'b01, 2'b10, 2'b00};
    logic [15:0] te [8] = '{16'hFFFF, 16'h0001, 16'h8000, 16'h0000, 16'hA5A5, 16'hA5A5, 16'hA5A5, 16'h8000};
    int lat; logic [15:0] rd, d, ex; logic rz, re, ri; logic [3:0] sh; logic [1:0] m; bit id;
    for (int i = 0; i < 8; i++) begin
      run_one(i[0], td[i], ts[i], tm[i], lat, rd, rz, re, ri);
      n_checks++; if (rd !== te[i] || rz !== (te[i] == 16'h0)) $display("FAIL mode_directed[%0d]: got %h z=%b want %h z=%b", i, rd, rz, te[i], te[i] == 16'h0); else n_pass++;
    end
    for (int i = 0; i < 40; i++) begin
      id = 1'($urandom_range(0, 1)); d = 16'($urandom); sh = 4'($urandom_range(0, 15)); m = 2'($urandom_range(0, 3));
      if (i % 8 == 0) sh = 4'd0;
      ex = ref_shift(d, sh, m);
      run_one(id, d, sh, m, lat, rd, rz, re, ri);
      n_checks++; if (lat !== 2) $display("FAIL rand_latency[%0d]: got %0d want 2", i, lat); else n_pass++;
      n_checks++; if (rd !== ex) $display("FAIL rand_data[%0d] d=%h sh=%0d m=%0d: got %h want %h", i, d, sh, m, rd, ex); else n_pass++;
      n_checks++; if ({ri, rz, re} !== {id, ex == 16'h0, m == 2'b11}) $display("FAIL rand_id_zero_err[%0d]: got %b want %b", i, {ri, rz, re}, {id, ex == 16'h0, m == 2'b11}); else n_pass++;
    end
  endtask

  task automatic test_arbitration();
    exp_t q[$]; exp_t e;
    int ngr, nresp, cyc, last;
    logic g0, g1, gid;
    logic [15:0] d [2]; logic [3:0] sh [2]; logic [1:0] m [2];
    pulse_reset();
    for (int k = 0; k < 2; k++) begin
      d[k] = 16'($urandom); sh[k] = 4'($urandom_range(0, 15)); m[k] = 2'($urandom_range(0, 2));
      set_req(k[0], 1'b1, d[k], sh[k], m[k]);
    end
    resp_ready = 1'b1;
    ngr = 0; nresp = 0; cyc = 0; last = -1;
    while ((ngr < 4 || nresp < 4) && cyc < 40) begin
      @(negedge clk); cyc++;
      if (resp_valid) begin
        if (q.size() == 0) begin
          n_checks++; $display("FAIL arb_unexpected_resp: got id %b want none", resp_id);
        end else begin
          e = q.pop_front();
          n_checks++; if (resp_id !== e.id || resp_data !== e.data) $display("FAIL arb_resp[%0d]: got id %b %h want id %b %h", nresp, resp_id, resp_data, e.id, e.data); else n_pass++;
        end
        nresp++;
      end
      g0 = req0_ready; g1 = req1_ready;
      n_checks++; if (g0 && g1) $display("FAIL arb_both_ready: got 11 want one-hot"); else n_pass++;
      if ((g0 || g1) && ngr < 4) begin
        gid = g1;
        n_checks++; if (gid !== 1'(ngr % 2) || gid !== m_prio) $display("FAIL arb_grant[%0d]: got %b want %b", ngr, gid, 1'(ngr % 2)); else n_pass++;
        if (last >= 0) begin
          n_checks++; if (cyc - last !== 3) $display("FAIL arb_spacing[%0d]: got %0d want 3", ngr, cyc - last); else n_pass++;
        end
        last = cyc;
        e.id = gid; e.data = ref_shift(d[gid], sh[gid], m[gid]);
        q.push_back(e);
        m_prio = !gid;
        ngr++;
        @(posedge clk); #1;
        d[gid] = 16'($urandom); sh[gid] = 4'($urandom_range(0, 15)); m[gid] = 2'($urandom_range(0, 2));
        set_req(gid, ngr < 4, d[gid], sh[gid], m[gid]);
        if (ngr == 4) set_req(!gid, 1'b0, 16'h0, 4'h0, 2'b00);
      end
    end
    n_checks++; if (ngr != 4 || nresp != 4) $display("FAIL arb_progress: got %0d grants %0d resps want 4 4", ngr, nresp); else n_pass++;
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure();
    int n; logic [15:0] d, hd; logic [3:0] sh; logic hid;
    d = 16'($urandom) | 16'h0100; sh = 4'($urandom_range(0, 7));
    resp_ready = 1'b0;
    set_req(0, 1'b1, d, sh, 2'b10);
    n = 0;
    @(negedge clk);
    while (!req0_ready && n < 20) begin @(negedge clk); n++; end
    n_checks++; if (n >= 20) $display("FAIL bp_accept: got no ready want ready"); else n_pass++;
    @(posedge clk); #1;
    set_req(0, 1'b0, 16'h0, 4'h0, 2'b00);
    m_prio = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!resp_valid && n < 20);
    hd = resp_data; hid = resp_id;
    n_checks++; if (hd !== ref_shift(d, sh, 2'b10) || hid !== 1'b0) $display("FAIL bp_resp: got id %b %h want id 0 %h", hid, hd, ref_shift(d, sh, 2'b10)); else n_pass++;
    #1 set_req(1, 1'b1, 16'h00FF, 4'd1, 2'b00);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_checks++; if (resp_valid !== 1'b1 || resp_data !== hd || resp_id !== hid || req0_ready !== 1'b0 || req1_ready !== 1'b0)
        $display("FAIL bp_hold[%0d]: got v=%b %h id=%b rdy=%b%b want v=1 %h id=%b rdy=00", i, resp_valid, resp_data, resp_id, req0_ready, req1_ready, hd, hid);
      else n_pass++;
    end
    #1 resp_ready = 1'b1;
    @(negedge clk);
    n_checks++; if (resp_valid !== 1'b0 || req1_ready !== 1'b1) $display("FAIL bp_release: got v=%b rdy1=%b want v=0 rdy1=1", resp_valid, req1_ready); else n_pass++;
    #1 set_req(1, 1'b0, 16'h0, 4'h0, 2'b00);
    @(negedge clk);
    n_checks++; if (resp_valid !== 1'b0) $display("FAIL bp_single_handshake: got v=%b want 0", resp_valid); else n_pass++;
    @(posedge clk); #1;
  endtask

  task automatic test_illegal();
    int lat; logic [15:0] rd; logic rz, re, ri;
    run_one(1, 16'h1234, 4'd3, 2'b11, lat, rd, rz, re, ri);
    n_checks++; if (rd !== 16'h0000 || {rz, re, ri} !== 3'b111) $display("FAIL illegal_resp: got %h z/e/id=%b want 0000 111", rd, {rz, re, ri}); else n_pass++;
    n_checks++; if (m_prio !== 1'b0) $display("FAIL illegal_prio_model: got %b want 0", m_prio); else n_pass++;
    run_one(0, 16'h00F0, 4'd2, 2'b00, lat, rd, rz, re, ri);
    n_checks++; if (lat !== 2 || rd !== 16'h03C0 || {rz, re, ri} !== 3'b000) $display("FAIL illegal_next: got lat %0d %h %b want 2 03c0 000", lat, rd, {rz, re, ri}); else n_pass++;
  endtask

  task automatic test_reset_midop();
    int n, lat; logic [15:0] rd; logic rz, re, ri;
    resp_ready = 1'b0;
    set_req(0, 1'b1, 16'h00F0, 4'd2, 2'b00);
    n = 0;
    @(negedge clk);
    while (!req0_ready && n < 20) begin @(negedge clk); n++; end
    @(posedge clk); #2 rst = 1'b1;
    #1;
    n_checks++; if ({resp_valid, resp_id, resp_zero, resp_err, req0_ready, req1_ready} !== 6'b0 || resp_data !== 16'h0)
      $display("FAIL rst_exec_outputs: got v=%b id=%b z=%b e=%b rdy=%b%b %h want all 0", resp_valid, resp_id, resp_zero, resp_err, req0_ready, req1_ready, resp_data);
    else n_pass++;
    set_req(0, 1'b0, 16'h0, 4'h0, 2'b00);
    repeat (2) @(negedge clk);
    @(posedge clk); #1 rst = 1'b0;
    m_prio = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_checks++; if (resp_valid !== 1'b0) $display("FAIL rst_exec_dropped[%0d]: got v=%b want 0", i, resp_valid); else n_pass++;
    end
    run_one(1, 16'h8001, 4'd1, 2'b01, lat, rd, rz, re, ri);
    n_checks++; if (lat !== 2 || rd !== 16'hC000 || ri !== 1'b1) $display("FAIL rst_fresh: got lat %0d %h id %b want 2 c000 1", lat, rd, ri); else n_pass++;
    resp_ready = 1'b0;
    set_req(0, 1'b1, 16'h0F0F, 4'd4, 2'b10);
    n = 0;
    do begin @(negedge clk); n++; end while (!resp_valid && n < 20);
    n_checks++; if (resp_data !== 16'hF0F0) $display("FAIL rst_resp_pre: got %h want f0f0", resp_data); else n_pass++;
    set_req(0, 1'b0, 16'h0, 4'h0, 2'b00);
    #1 rst = 1'b1;
    #1;
    n_checks++; if (resp_valid !== 1'b0 || resp_data !== 16'h0 || resp_id !== 1'b0) $display("FAIL rst_resp_outputs: got v=%b %h id=%b want 0 0000 0", resp_valid, resp_data, resp_id); else n_pass++;
    @(posedge clk); #1 rst = 1'b0;
    m_prio = 1'b0;
    resp_ready = 1'b1;
    @(negedge clk);
    n_checks++; if (resp_valid !== 1'b0) $display("FAIL rst_resp_dropped: got v=%b want 0", resp_valid); else n_pass++;
  endtask

  initial begin
    req0_valid = 0; req0_data = 0; req0_shamt = 0; req0_mode = 0;
    req1_valid = 0; req1_data = 0; req1_shamt = 0; req1_mode = 0;
    resp_ready = 0; rst = 1;
    test_reset();
    test_single();
    test_modes();
    test_arbitration();
    test_backpressure();
    test_illegal();
    test_reset_midop();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/shift_arbiter.md
# shift_arbiter

Shares one 16-bit barrel `shifter` between two requesters, e.g. the EX-stage ALU and a multi-cycle address/immediate unit, so only one shifter instance is needed. Each requester uses a valid/ready request channel. A round-robin arbiter grants one request at a time, latches its operands and runs them through the shifter. It returns a registered result, Zero flag and requester ID on a valid/ready response channel.

## Interface
Parameters:
- PRIO_INIT, default 0: requester favoured by the round-robin pointer after reset (0 or 1).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- req0_valid  in  1  requester 0 has a request.
- req0_ready  out  1  requester 0 request accepted this cycle.
- req0_data  in  16  operand to shift.
- req0_shamt  in  4  shift amount 0–15.
- req0_mode  in  2  00 SLL, 01 SRA, 10 ROR, 11 illegal.
- req1_valid, req1_ready, req1_data, req1_shamt, req1_mode: same widths and meanings for requester 1.
- resp_valid  out  1  response available.
- resp_ready  in  1  consumer takes the response.
- resp_id  out  1  requester that issued the response.
- resp_data  out  16  shift result.
- resp_zero  out  1  resp_data == 0.
- resp_err  out  1  request carried mode 11.

## Operation
- State machine with states IDLE, EXEC and RESP. Reset enters IDLE.
- IDLE:
  - If any reqN_valid is high, grant one requester. If only one is valid, grant that one. If both are valid, grant the one named by the priority pointer `prio`.
  - reqN_ready is combinational and high only for the granted requester, only in IDLE. The non-granted ready is 0.
  - On handshake (valid & ready): latch data, shamt and mode into operand registers, record the grant ID, set prio to the other requester, go to EXEC.
- EXEC:
  - The shifter sees only the latched operands.
  - At the end of the cycle, register resp_data, resp_zero, resp_err and resp_id, set resp_valid=1, go to RESP.
- RESP:
  - Hold all resp_* outputs stable and keep both reqN_ready=0.
  - When resp_valid & resp_ready, clear resp_valid and go to IDLE.
- Shift semantics:
  - SLL fills with zeros.
  - SRA fills with data[15].
  - ROR rotates right.
  - shamt=0 passes the data through unchanged for all legal modes.
- Mode 11: resp_data=0x0000, resp_zero=1, resp_err=1. The prio update still occurs.
- resp_zero and resp_err are valid only while resp_valid=1.
- Requester rule: a request held on valid must stay stable until its ready is seen. The block does not check this.

## Timing
- Reset values:
  - state=IDLE, prio=PRIO_INIT.
  - resp_valid=0, resp_id=0, resp_data=0, resp_zero=0, resp_err=0.
  - Operand registers are 0.
  - Both reqN_ready are 0 while rst is high.
- Latency: request accepted at edge N; resp_valid is high from the cycle after edge N+1, i.e. 2 cycles after acceptance.
- Throughput:
  - At most one request every 3 cycles, reached when resp_ready is held high.
  - No new request is accepted in the cycle the response handshakes; acceptance resumes in IDLE on the next cycle.
- Back-pressure: resp_ready held low keeps the block in RESP indefinitely. The outputs do not change and no request is accepted.
- Simultaneous requests: the loser keeps its valid and is granted at the next IDLE. With both valid continuously, grants alternate 0,1,0,1 (PRIO_INIT=0).
- Reset mid-operation, in EXEC or RESP:
  - The in-flight request is dropped with no response.
  - All outputs go to their reset values immediately, because reset is asynchronous.

## Test plan
- Single request: req0 SLL data=0x0001 shamt=4 accepted at edge N -> resp_valid at N+2 with resp_data=0x0010, resp_id=0, resp_zero=0, resp_err=0; resp_ready=1 returns the block to IDLE.
- Mode coverage:
  - SRA 0x8000 by 15 -> 0xFFFF.
  - SRA 0x4000 by 14 -> 0x0001.
  - ROR 0x0001 by 1 -> 0x8000.
  - SLL 0x8000 by 1 -> 0x0000 with resp_zero=1.
  - shamt=0 on 0xA5A5 returns 0xA5A5 for each mode.
- Arbitration: PRIO_INIT=0, both valid continuously with resp_ready=1 -> grant order and resp_id sequence 0,1,0,1. Each grant is 3 cycles apart. The non-granted ready stays 0.
- Back-pressure: resp_ready held low 5 cycles in RESP -> resp_data and resp_id stable, both readies 0; release yields one handshake and then IDLE.
- Illegal mode: req1 mode=11 data=0x1234 -> resp_data=0x0000, resp_zero=1, resp_err=1, resp_id=1; the next request is granted normally.
- Reset in EXEC: assert rst during EXEC -> resp_valid never rises, all outputs at their reset values; after deassertion a fresh request completes with normal latency.
